// File: rtl/cam_capture_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cam_capture_ctrl                                           |
// | Description : Frame capture sequencer for a parallel camera port. It     |
// |               arms on a start request, skips any partial frame, holds    |
// |               the capture datapath in reset outside the active frame,    |
// |               counts pixel writes and grades each frame as good (pixel   |
// |               count == NPIX) or bad. Single-shot or continuous mode.     |
// | Options     : `define CAM_CTRL_WATCHDOG_EN adds a TMO-cycle watchdog on  |
// |               the ARM, SYNC and CAPT states.                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   CAM_pclk     in   1   pixel clock, all logic on its rising edge        |
// |   rst          in   1   asynchronous active-low reset                    |
// |   start        in   1   one-cycle capture request (accepted in IDLE)     |
// |   cont         in   1   sampled with start: 1 continuous, 0 single       |
// |   stop         in   1   end continuous capture after the current frame   |
// |   CAM_vsync    in   1   camera vertical sync, high between frames        |
// |   DP_RAM_regW  in   1   pixel write strobe from the capture datapath     |
// |   cap_rst      out  1   hold for the capture datapath, low only in CAPT  |
// |   busy         out  1   high whenever the sequencer is not idle          |
// |   frame_done   out  1   one-cycle pulse, good frame                      |
// |   frame_err    out  1   one-cycle pulse, bad frame or watchdog expiry    |
// |   frame_cnt    out  8   good-frame counter, wraps                        |
// |   px_cnt       out  PW  pixel writes in the current or last frame        |
// +--------------------------------------------------------------------------+

module cam_capture_ctrl #(
   parameter int NPIX = 19200,
   parameter int PW   = 15,
   parameter int TMO  = 1000000
) (
   input  logic          CAM_pclk,
   input  logic          rst,
   input  logic          start,
   input  logic          cont,
   input  logic          stop,
   input  logic          CAM_vsync,
   input  logic          DP_RAM_regW,
   output logic          cap_rst,
   output logic          busy,
   output logic          frame_done,
   output logic          frame_err,
   output logic [7:0]    frame_cnt,
   output logic [PW-1:0] px_cnt
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ARM  = 3'd1;
   localparam logic [2:0] S_SYNC = 3'd2;
   localparam logic [2:0] S_CAPT = 3'd3;
   localparam logic [2:0] S_END  = 3'd4;

   localparam logic [PW-1:0] PX_MAX  = {PW{1'b1}};
   localparam logic [PW-1:0] PX_GOOD = PW'(NPIX);

   logic [2:0]    state;
   logic [2:0]    state_nxt;
   logic          mode_r;
   logic          stop_pend;
   logic          wd_hit;
   logic [PW-1:0] px_nxt;
   logic          going_end;
   logic          end_good;
   logic          end_bad;

   // ------------------------------------------------------------------------
   // Next-state logic. A watchdog expiry overrides every other transition.
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (start && !stop) state_nxt = S_ARM;
         // Waiting for vsync high means a frame already in flight is skipped.
         S_ARM:  if (stop)            state_nxt = S_IDLE;
                 else if (CAM_vsync)  state_nxt = S_SYNC;
         S_SYNC: if (stop)            state_nxt = S_IDLE;
                 else if (!CAM_vsync) state_nxt = S_CAPT;
         S_CAPT: if (CAM_vsync)       state_nxt = S_END;
         S_END:  if (mode_r && !stop_pend && !stop) state_nxt = S_ARM;
                 else                               state_nxt = S_IDLE;
         default:                     state_nxt = S_IDLE;
      endcase
      if (wd_hit) state_nxt = S_IDLE;
   end

   // ------------------------------------------------------------------------
   // Pixel counter: cleared as the frame opens, saturating while capturing.
   // ------------------------------------------------------------------------
   always_comb begin
      px_nxt = px_cnt;
      if (state == S_SYNC && state_nxt == S_CAPT) begin
         px_nxt = '0;
      end else if (state == S_CAPT && DP_RAM_regW && px_cnt != PX_MAX) begin
         px_nxt = px_cnt + PW'(1);
      end
   end

   // The frame is graded one cycle early so that the pulses are registered
   // and line up with the END state. A write on the closing vsync cycle
   // still counts towards the frame.
   assign going_end = (state == S_CAPT) && (state_nxt == S_END);
   assign end_good  = going_end && (px_nxt == PX_GOOD);
   assign end_bad   = (going_end && !end_good) || wd_hit;

`ifdef CAM_CTRL_WATCHDOG_EN
   // ------------------------------------------------------------------------
   // Watchdog: counts cycles spent in a waiting state, restarts on any state
   // change. Expiry is flagged on the cycle that would make the count TMO.
   // ------------------------------------------------------------------------
   localparam int WDW = $clog2(TMO + 1);
   localparam logic [WDW-1:0] WD_LAST = WDW'(TMO - 1);

   logic [WDW-1:0] wd_cnt;
   logic           wd_run;

   assign wd_run = (state == S_ARM) || (state == S_SYNC) || (state == S_CAPT);
   assign wd_hit = wd_run && (wd_cnt == WD_LAST);

   always_ff @(posedge CAM_pclk or negedge rst) begin
      if (!rst) begin
         wd_cnt <= '0;
      end else if (state_nxt != state) begin
         wd_cnt <= '0;
      end else if (wd_run) begin
         wd_cnt <= wd_cnt + WDW'(1);
      end
   end
`else
   assign wd_hit = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // State and registered outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge CAM_pclk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         cap_rst    <= 1'b1;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         frame_cnt  <= 8'd0;
         px_cnt     <= '0;
         mode_r     <= 1'b0;
         stop_pend  <= 1'b0;
      end else begin
         state      <= state_nxt;
         busy       <= (state_nxt != S_IDLE);
         cap_rst    <= (state_nxt != S_CAPT);
         frame_done <= end_good;
         frame_err  <= end_bad;
         px_cnt     <= px_nxt;
         if (end_good) begin
            frame_cnt <= frame_cnt + 8'd1;
         end
         if (state == S_IDLE && state_nxt == S_ARM) begin
            mode_r <= cont;
         end
         // Idle (including the cycle of entry) discards any pending stop.
         if (state_nxt == S_IDLE) begin
            stop_pend <= 1'b0;
         end else if (stop) begin
            stop_pend <= 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_cam_capture_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_cam_capture_ctrl                                        |
// | Description : Self-checking bench for cam_capture_ctrl. Uses a small     |
// |               frame (NPIX=40, PW=6) so that full frames, saturation and  |
// |               continuous runs stay short; TMO=100.                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

module tb_cam_capture_ctrl;

   localparam int NPIX = 40;
   localparam int PW   = 6;
   localparam int TMO  = 100;
   localparam int OW   = PW + 12;

   logic          CAM_pclk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          cont = 1'b0;
   logic          stop = 1'b0;
   logic          CAM_vsync = 1'b0;
   logic          DP_RAM_regW = 1'b0;
   logic          cap_rst;
   logic          busy;
   logic          frame_done;
   logic          frame_err;
   logic [7:0]    frame_cnt;
   logic [PW-1:0] px_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 CAM_pclk = ~CAM_pclk;

   cam_capture_ctrl #(
      .NPIX (NPIX),
      .PW   (PW),
      .TMO  (TMO)
   ) dut (
      .CAM_pclk    (CAM_pclk),
      .rst         (rst),
      .start       (start),
      .cont        (cont),
      .stop        (stop),
      .CAM_vsync   (CAM_vsync),
      .DP_RAM_regW (DP_RAM_regW),
      .cap_rst     (cap_rst),
      .busy        (busy),
      .frame_done  (frame_done),
      .frame_err   (frame_err),
      .frame_cnt   (frame_cnt),
      .px_cnt      (px_cnt)
   );

   typedef struct {
      logic          st;
      logic          ct;
      logic          sp;
      logic          vs;
      logic          rw;
      int            ncyc;
      logic [OW-1:0] exp;
   } vec_t;

   vec_t tv[$];

   function automatic logic [OW-1:0] pack(input logic b, input logic cr, input logic d,
                                          input logic e, input int fc, input int px);
      return {b, cr, d, e, 8'(fc), PW'(px)};
   endfunction

   function automatic string fmt(input logic [OW-1:0] x);
      return $sformatf("busy=%b cap_rst=%b done=%b err=%b fcnt=%0d px=%0d",
                       x[OW-1], x[OW-2], x[OW-3], x[OW-4], x[PW+7:PW], x[PW-1:0]);
   endfunction

   task automatic add(input logic s, input logic c, input logic p, input logic v,
                      input logic w, input int n, input logic b, input logic cr,
                      input logic d, input logic e, input int fc, input int px);
      vec_t r;
      r.st = s; r.ct = c; r.sp = p; r.vs = v; r.rw = w; r.ncyc = n;
      r.exp = pack(b, cr, d, e, fc, px);
      tv.push_back(r);
   endtask

   task automatic tick();
      @(posedge CAM_pclk);
      #1;
   endtask

   task automatic chk(input string name, input logic [OW-1:0] exp);
      logic [OW-1:0] act;
      act = {busy, cap_rst, frame_done, frame_err, frame_cnt, px_cnt};
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %s, expected %s", name, fmt(act), fmt(exp));
      end
   endtask

   initial begin
      // ---- vector table: start cont stop vsync regW ncyc | busy cap done err fcnt px
      // single good frame, regW ignored in ARM and IDLE
      add(1,0,0,0,0,  1,  1,1,0,0, 0, 0);   // 0  IDLE->ARM
      add(0,0,0,0,1,  5,  1,1,0,0, 0, 0);   // 1  ARM waits, no counting
      add(0,0,0,1,0,  1,  1,1,0,0, 0, 0);   // 2  ARM->SYNC
      add(0,0,0,1,0,  3,  1,1,0,0, 0, 0);   // 3  SYNC holds while vsync high
      add(0,0,0,0,0,  1,  1,0,0,0, 0, 0);   // 4  SYNC->CAPT, cap_rst falls
      add(0,0,0,0,1, 40,  1,0,0,0, 0,40);   // 5  40 writes
      add(0,0,0,1,0,  1,  1,1,1,0, 1,40);   // 6  END, good
      add(0,0,0,1,0,  1,  0,1,0,0, 1,40);   // 7  single mode -> IDLE
      add(0,0,0,1,1,  3,  0,1,0,0, 1,40);   // 8  px held in IDLE
      // short frame, write on the closing vsync cycle counts
      add(1,0,0,1,0,  1,  1,1,0,0, 1,40);   // 9  start does not clear px
      add(0,0,0,1,0,  1,  1,1,0,0, 1,40);   // 10 SYNC
      add(0,0,0,0,0,  1,  1,0,0,0, 1, 0);   // 11 CAPT, px cleared
      add(0,0,0,0,1, 30,  1,0,0,0, 1,30);   // 12
      add(0,0,0,1,1,  1,  1,1,0,1, 1,31);   // 13 END, bad
      add(0,0,0,1,0,  1,  0,1,0,0, 1,31);   // 14 IDLE
      // saturation at 2^PW-1
      add(1,0,0,1,0,  1,  1,1,0,0, 1,31);   // 15 ARM
      add(0,0,0,1,0,  1,  1,1,0,0, 1,31);   // 16 SYNC
      add(0,0,0,0,0,  1,  1,0,0,0, 1, 0);   // 17 CAPT
      add(0,0,0,0,1, 70,  1,0,0,0, 1,63);   // 18 saturates
      add(0,0,0,1,0,  1,  1,1,0,1, 1,63);   // 19 END, bad
      add(0,0,0,1,0,  1,  0,1,0,0, 1,63);   // 20 IDLE
      // stop handling
      add(1,0,1,1,0,  1,  0,1,0,0, 1,63);   // 21 start+stop in IDLE: stop wins
      add(1,1,0,0,0,  1,  1,1,0,0, 1,63);   // 22 ARM
      add(0,0,1,0,0,  1,  0,1,0,0, 1,63);   // 23 stop in ARM -> IDLE
      add(1,1,0,1,0,  1,  1,1,0,0, 1,63);   // 24 ARM
      add(0,0,0,1,0,  1,  1,1,0,0, 1,63);   // 25 SYNC
      add(0,0,1,1,0,  1,  0,1,0,0, 1,63);   // 26 stop in SYNC -> IDLE
      // start mid-frame: nothing counted until the next vsync high->low
      add(1,0,0,0,1,  1,  1,1,0,0, 1,63);   // 27 ARM
      add(0,0,0,0,1, 10,  1,1,0,0, 1,63);   // 28 partial frame skipped
      add(0,0,0,1,1,  1,  1,1,0,0, 1,63);   // 29 SYNC
      add(0,0,0,0,1,  1,  1,0,0,0, 1, 0);   // 30 CAPT
      add(1,1,0,0,1, 40,  1,0,0,0, 1,40);   // 31 start in CAPT ignored
      add(0,0,0,1,0,  1,  1,1,1,0, 2,40);   // 32 END, good
      add(0,0,0,1,0,  1,  0,1,0,0, 2,40);   // 33 mode stayed single -> IDLE

      // ---- reset state; start held during reset is not accepted
      start = 1'b1;
      tick();
      chk("reset_state", pack(0,1,0,0, 0, 0));
      tick();
      chk("reset_start_held", pack(0,1,0,0, 0, 0));
      start = 1'b0;
      rst   = 1'b1;
      tick();
      chk("reset_release_idle", pack(0,1,0,0, 0, 0));

      // ---- table
      foreach (tv[i]) begin
         start       = tv[i].st;
         cont        = tv[i].ct;
         stop        = tv[i].sp;
         CAM_vsync   = tv[i].vs;
         DP_RAM_regW = tv[i].rw;
         repeat (tv[i].ncyc) tick();
         chk($sformatf("vec%0d", i), tv[i].exp);
      end

      // ---- continuous mode, stop during the third CAPT
      start = 1'b1; cont = 1'b1; stop = 1'b0; CAM_vsync = 1'b1; DP_RAM_regW = 1'b0;
      tick();
      start = 1'b0; cont = 1'b0;
      chk("cont_arm", pack(1,1,0,0, 2,40));
      for (int f = 0; f < 3; f++) begin
         CAM_vsync = 1'b1;
         tick();
         CAM_vsync = 1'b0;
         tick();
         DP_RAM_regW = 1'b1;
         for (int p = 0; p < NPIX; p++) begin
            stop = (f == 2 && p == 10);
            tick();
         end
         stop = 1'b0; DP_RAM_regW = 1'b0; CAM_vsync = 1'b1;
         tick();
         chk($sformatf("cont_end%0d", f), pack(1,1,1,0, 3+f, 40));
         tick();
         if (f < 2) chk($sformatf("cont_rearm%0d", f), pack(1,1,0,0, 3+f, 40));
         else       chk("cont_stop_idle", pack(0,1,0,0, 5, 40));
      end

      // ---- asynchronous reset in the middle of a frame
      start = 1'b1; cont = 1'b0; CAM_vsync = 1'b1;
      tick();
      start = 1'b0;
      tick();
      CAM_vsync = 1'b0;
      tick();
      DP_RAM_regW = 1'b1;
      repeat (20) tick();
      chk("mid_capt", pack(1,0,0,0, 5,20));
      #3 rst = 1'b0;
      #1;
      chk("async_reset", pack(0,1,0,0, 0, 0));
      DP_RAM_regW = 1'b0; CAM_vsync = 1'b1;
      tick();
      tick();
      chk("reset_no_pulse", pack(0,1,0,0, 0, 0));
      rst = 1'b1;
      tick();
      chk("reset_after", pack(0,1,0,0, 0, 0));

`ifdef CAM_CTRL_WATCHDOG_EN
      // ---- watchdog: vsync never rises
      CAM_vsync = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (TMO - 1) tick();
      chk("wd_before", pack(1,1,0,0, 0, 0));
      tick();
      chk("wd_fire", pack(0,1,0,1, 0, 0));
      tick();
      chk("wd_once", pack(0,1,0,0, 0, 0));
`else
      // ---- no watchdog: ARM waits indefinitely
      CAM_vsync = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (150) tick();
      chk("arm_wait", pack(1,1,0,0, 0, 0));
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("arm_stop", pack(0,1,0,0, 0, 0));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/cam_capture_ctrl.md
CAM_CAPTURE_CTRL -- requirements
Module: cam_capture_ctrl

Interface
REQ-001 SHALL have parameter NPIX, default 19200, meaning pixels per frame (160x120 RGB444).
REQ-002 SHALL have parameter PW, default 15, meaning width of pixel counter; NPIX must fit in PW bits.
REQ-003 SHALL have parameter TMO, default 1000000, meaning watchdog limit in CAM_pclk cycles.
REQ-004 CAM_pclk  input  1  sole clock, all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle request to capture.
REQ-007 cont  input  1  sampled with start: 1 = continuous frames, 0 = single frame.
REQ-008 stop  input  1  ends continuous capture after the current frame.
REQ-009 CAM_vsync  input  1  camera vertical sync, high between frames.
REQ-010 DP_RAM_regW  input  1  write strobe from the capture datapath, one cycle per pixel.
REQ-011 cap_rst  output  1  active-high hold for the capture datapath.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 frame_done  output  1  one-cycle pulse at the end of a good frame.
REQ-014 frame_err  output  1  one-cycle pulse at the end of a bad frame.
REQ-015 frame_cnt  output  8  count of good frames, wraps 255->0.
REQ-016 px_cnt  output  PW  count of pixel writes in the current or last frame.

Function
REQ-017 The FSM SHALL have the states IDLE, ARM, SYNC, CAPT and END.
- IDLE: start=1 -> ARM; latch cont into mode_r.
- ARM: wait for CAM_vsync=1 -> SYNC. This skips any partial frame.
- SYNC: CAM_vsync=0 -> CAPT; clear px_cnt on this transition.
- CAPT: CAM_vsync=1 -> END.
- END: lasts one cycle -> ARM if mode_r=1 and no stop is pending, else IDLE.
REQ-018 cap_rst SHALL be 1 in IDLE, ARM, SYNC and END, and 0 only in CAPT.
- cap_rst is a registered output.
- cap_rst falls on the cycle after vsync is seen low in SYNC.
REQ-019 In CAPT, each cycle with DP_RAM_regW=1 SHALL increment px_cnt.
- px_cnt saturates at 2^PW-1 and does not wrap.
- DP_RAM_regW is ignored outside CAPT.
REQ-020 On the END cycle, the frame is checked:
- px_cnt == NPIX: frame_done=1 and frame_cnt increments.
- otherwise: frame_err=1 and frame_cnt is unchanged.
- frame_done and frame_err are never high together.
REQ-021 A stop in any state SHALL set stop_pend.
- stop_pend is cleared on entry to IDLE.
- A stop in IDLE has no effect.
- A stop in ARM or SYNC returns the FSM to IDLE on the next cycle with no frame pulse.
REQ-022 start outside IDLE SHALL be ignored. start and stop in the same IDLE cycle: stop wins, FSM stays in IDLE.
REQ-023 px_cnt SHALL hold its value in IDLE for readout.
- It is not cleared by start.
- It is cleared only on the SYNC->CAPT transition.
REQ-024 All outputs SHALL be registered, with no combinational path from input to output.

Reset
REQ-025 rst=0 SHALL asynchronously force the following:
- state = IDLE
- cap_rst = 1
- busy = 0
- frame_done = 0 and frame_err = 0
- frame_cnt = 0 and px_cnt = 0
- mode_r = 0, stop_pend = 0 and the watchdog = 0.
REQ-026 Reset release SHALL take effect on the first CAM_pclk rising edge with rst=1; no start is accepted before that edge.
REQ-027 Reset during CAPT SHALL abort the frame with no frame_done or frame_err pulse.

Configuration
REQ-028 Macro CAM_CTRL_WATCHDOG_EN, when defined, SHALL add a cycle counter.
- The counter is cleared on every state change and counts in ARM, SYNC and CAPT.
- When it reaches TMO: frame_err pulses once, the FSM goes to IDLE and cap_rst returns to 1.
REQ-029 Without CAM_CTRL_WATCHDOG_EN there SHALL be no counter logic, and ARM, SYNC and CAPT wait indefinitely.

Verification
REQ-030 Single frame: start with cont=0, then vsync high, low, 19200 regW pulses, vsync high -> one frame_done, frame_cnt=1, px_cnt=19200, IDLE, busy=0.
REQ-031 Short frame: as REQ-030 with 19000 pulses -> frame_err=1, frame_done=0, frame_cnt=0, px_cnt=19000.
REQ-032 Continuous with stop: start with cont=1, 3 frames, stop asserted during the 3rd CAPT -> 3 frame_done pulses, frame_cnt=3, then IDLE after the 3rd END.
REQ-033 Mid-frame start: start while vsync=0 and regW is active -> cap_rst stays 1 and no counting until the next vsync high->low.
REQ-034 Reset: rst=0 for 1 ns mid-CAPT at px_cnt=5000 -> all outputs at reset values immediately, no frame pulse.
REQ-035 Watchdog (macro defined, TMO=100): start with vsync held 0 -> frame_err pulse 100 cycles after entering ARM, then IDLE.
